// File: rtl/func_eval_pkg.sv
// Shared constants and helpers for the func_eval pipeline.
package func_eval_pkg;

    localparam logic [1:0] MODE_AND     = 2'd0;
    localparam logic [1:0] MODE_NAND    = 2'd1;
    localparam logic [1:0] MODE_XOR     = 2'd2;
    localparam logic [1:0] MODE_OR_NOTD = 2'd3;

    // Ceiling log2 for elaboration-time width derivation; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/func_eval_stage.sv
// One valid/ready register slice; accepts a new word whenever it is empty or draining.
module func_eval_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          load;

    assign load    = !valid_q || ready_i;
    assign ready_o = load;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/func_eval_pipe.sv
// Two-stage valid/ready evaluator of (a^b)&(c|~d) and its variants, with a saturating
// running count of asserted result lanes.
module func_eval_pipe
    import func_eval_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc,
    output logic             acc_sat
);

    localparam int unsigned PW  = clog2(WIDTH + 1);
    localparam int unsigned SW  = ACC_W + 1;
    localparam int unsigned S1W = 2 + 2 * WIDTH;
    localparam logic [ACC_W:0] AccMax = {1'b0, {ACC_W{1'b1}}};

    logic [S1W-1:0]   s1_in;
    logic [S1W-1:0]   s1_out;
    logic             s1_ready;
    logic             s1_valid;
    logic             s2_ready;
    logic [1:0]       s1_mode;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [WIDTH-1:0] f_d;

    assign s1_in    = {mode, a ^ b, c | ~d};
    assign in_ready = !rst && s1_ready;

    func_eval_stage #(
        .DW(S1W)
    ) u_stage1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(in_valid),
        .ready_o(s1_ready),
        .data_i (s1_in),
        .valid_o(s1_valid),
        .ready_i(s2_ready),
        .data_o (s1_out)
    );

    assign s1_mode = s1_out[S1W-1 -: 2];
    assign s1_x    = s1_out[2*WIDTH-1 -: WIDTH];
    assign s1_y    = s1_out[WIDTH-1:0];

    always_comb begin
        f_d = s1_x & s1_y;
        case (s1_mode)
            MODE_AND:     f_d = s1_x & s1_y;
            MODE_NAND:    f_d = ~(s1_x & s1_y);
            MODE_XOR:     f_d = s1_x;
            MODE_OR_NOTD: f_d = s1_y;
            default:      f_d = s1_x & s1_y;
        endcase
    end

    func_eval_stage #(
        .DW(WIDTH)
    ) u_stage2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .valid_i(s1_valid),
        .ready_o(s2_ready),
        .data_i (f_d),
        .valid_o(out_valid),
        .ready_i(out_ready),
        .data_o (f)
    );

    logic [PW-1:0]    pop;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(f[i]);
        end
    end

    // One spare bit so the compare sees the true sum before clamping.
    assign sum = {1'b0, acc_q} + SW'(pop);

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (acc_clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (out_valid && out_ready) begin
            if (sum >= AccMax) begin
                acc_d = AccMax[ACC_W-1:0];
                sat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc     = acc_q;
    assign acc_sat = sat_q;

endmodule

// File: tb/tb_func_eval_pipe.sv
// Randomised and directed bench for func_eval_pipe against a spec-level reference model.
module tb_func_eval_pipe;

    typedef struct {
        logic [1:0] m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        int         cyc;
    } beat_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       acc_clr;
    logic [1:0] mode;
    logic [7:0] a, b, c, d;

    logic        in_ready8, out_valid8, sat8;
    logic [7:0]  f8;
    logic [15:0] acc8;
    logic        in_ready1, out_valid1, sat1;
    logic [0:0]  f1;
    logic [15:0] acc1;
    logic        in_readys, out_valids, sats;
    logic [7:0]  fs;
    logic [3:0]  accs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t      in_q[$];
    logic [7:0] out8_q[$];
    logic [0:0] out1_q[$];
    logic [7:0] outs_q[$];
    int         outcyc_q[$];

    logic       pre_in_ready;
    logic       pre_out_valid;
    logic [7:0] pre_f;

    func_eval_pipe #(.WIDTH(8), .ACC_W(16)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .out_valid(out_valid8), .out_ready(out_ready), .f(f8),
        .acc_clr(acc_clr), .acc(acc8), .acc_sat(sat8)
    );

    func_eval_pipe #(.WIDTH(1), .ACC_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a[0:0]), .b(b[0:0]), .c(c[0:0]), .d(d[0:0]), .mode(mode),
        .out_valid(out_valid1), .out_ready(out_ready), .f(f1),
        .acc_clr(acc_clr), .acc(acc1), .acc_sat(sat1)
    );

    func_eval_pipe #(.WIDTH(8), .ACC_W(4)) u_duts (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_readys),
        .a(a), .b(b), .c(c), .d(d), .mode(mode),
        .out_valid(out_valids), .out_ready(out_ready), .f(fs),
        .acc_clr(acc_clr), .acc(accs), .acc_sat(sats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_f(input beat_t bt);
        logic [7:0] x, y;
        x = bt.a ^ bt.b;
        y = bt.c | ~bt.d;
        case (bt.m)
            2'd0:    return x & y;
            2'd1:    return ~(x & y);
            2'd2:    return x;
            default: return y;
        endcase
    endfunction

    function automatic int clamp(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Drive one clock of inputs, record pre-edge handshakes, then advance past the edge.
    task automatic cycle(input logic r, input logic iv, input logic ordy, input logic clr,
                         input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] cv, input logic [7:0] dv);
        beat_t bt;
        rst = r; in_valid = iv; out_ready = ordy; acc_clr = clr;
        mode = m; a = av; b = bv; c = cv; d = dv;
        #1;
        pre_in_ready  = in_ready8;
        pre_out_valid = out_valid8;
        pre_f         = f8;
        if (!r && iv && in_ready8) begin
            bt.m = m; bt.a = av; bt.b = bv; bt.c = cv; bt.d = dv; bt.cyc = cyc;
            in_q.push_back(bt);
        end
        if (!r && out_valid8 && ordy) begin
            out8_q.push_back(f8);
            out1_q.push_back(f1);
            outs_q.push_back(fs);
            outcyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input logic ordy, input logic clr);
        cycle(1'b0, 1'b0, ordy, clr, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic clear_queues();
        in_q.delete(); out8_q.delete(); out1_q.delete(); outs_q.delete(); outcyc_q.delete();
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'h00);
        checks++;
        if (pre_in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", pre_in_ready);
        end
        checks++;
        if ({out_valid8, out_valid1, out_valids} !== 3'b000) begin
            errors++; $display("FAIL reset_out_valid: got %b want 000",
                               {out_valid8, out_valid1, out_valids});
        end
        checks++;
        if (f8 !== 8'h00 || fs !== 8'h00 || f1 !== 1'b0) begin
            errors++; $display("FAIL reset_f: got %h/%h/%b want 0", f8, fs, f1);
        end
        checks++;
        if (acc8 !== 16'd0 || accs !== 4'd0 || sat8 !== 1'b0 || sats !== 1'b0) begin
            errors++; $display("FAIL reset_acc: got %0d/%0d sat %b/%b want 0", acc8, accs,
                               sat8, sats);
        end
        idle(1'b1, 1'b0);
        checks++;
        if (pre_in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready: got %b want 1", pre_in_ready);
        end
    endtask

    task automatic test_truth_table();
        logic [3:0] v;
        logic       exp;
        clear_queues();
        idle(1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, {8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}});
        end
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
        checks++;
        if (out1_q.size() != 16 || in_q.size() != 16) begin
            errors++; $display("FAIL tt_count: got %0d outputs %0d inputs want 16",
                               out1_q.size(), in_q.size());
        end
        for (int k = 0; k < 16 && k < out1_q.size() && k < in_q.size(); k++) begin
            v = 4'(k);
            exp = (v[3] ^ v[2]) & (v[1] | ~v[0]);
            checks++;
            if (out1_q[k] !== exp) begin
                errors++; $display("FAIL tt_f[%0d]: got %b want %b", k, out1_q[k], exp);
            end
            checks++;
            if (outcyc_q[k] - in_q[k].cyc != 2) begin
                errors++; $display("FAIL tt_latency[%0d]: got %0d want 2", k,
                                   outcyc_q[k] - in_q[k].cyc);
            end
        end
        checks++;
        if (out1_q.size() > 9 && (out1_q[9] !== 1'b0 || out1_q[8] !== 1'b1)) begin
            errors++; $display("FAIL tt_examples: got 1001->%b 1000->%b want 0,1",
                               out1_q[9], out1_q[8]);
        end
    endtask

    task automatic test_modes();
        int sum;
        logic [7:0] exp;
        clear_queues();
        idle(1'b1, 1'b1);
        for (int m = 0; m < 4; m++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'(m), 8'hF0, 8'hFF, 8'h00, 8'h0F);
        end
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
        checks++;
        if (out8_q.size() != 4) begin
            errors++; $display("FAIL modes_count: got %0d want 4", out8_q.size());
        end
        sum = 0;
        for (int k = 0; k < out8_q.size() && k < in_q.size(); k++) begin
            exp = model_f(in_q[k]);
            sum += $countones(exp);
            checks++;
            if (out8_q[k] !== exp || in_q[k].m != 2'(k)) begin
                errors++; $display("FAIL modes_f[%0d]: got %h want %h", k, out8_q[k], exp);
            end
        end
        checks++;
        if (acc8 !== 16'd16 || int'(acc8) != sum) begin
            errors++; $display("FAIL modes_acc: got %0d want 16", acc8);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int sum;
        logic [7:0] exp;
        clear_queues();
        idle(1'b1, 1'b1);
        held = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 8'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom));
            if (i == 2) held = pre_f;
            if (i >= 2) begin
                checks++;
                if (pre_out_valid !== 1'b1 || pre_f !== held) begin
                    errors++; $display("FAIL bp_stable[%0d]: got v=%b f=%h want v=1 f=%h", i,
                                       pre_out_valid, pre_f, held);
                end
            end
        end
        checks++;
        if (in_q.size() != 2 || pre_in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accepted: got %0d beats in_ready=%b want 2 and 0",
                               in_q.size(), pre_in_ready);
        end
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
        checks++;
        if (out8_q.size() != in_q.size()) begin
            errors++; $display("FAIL bp_out_count: got %0d want %0d", out8_q.size(),
                               in_q.size());
        end
        sum = 0;
        for (int k = 0; k < out8_q.size() && k < in_q.size(); k++) begin
            exp = model_f(in_q[k]);
            sum += $countones(exp);
            checks++;
            if (out8_q[k] !== exp) begin
                errors++; $display("FAIL bp_f[%0d]: got %h want %h", k, out8_q[k], exp);
            end
        end
        checks++;
        if (int'(acc8) != sum) begin
            errors++; $display("FAIL bp_acc: got %0d want %0d", acc8, sum);
        end
    endtask

    task automatic send_ones(input logic clr);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'h00);
        idle(1'b1, 1'b0);
        idle(1'b1, clr);
    endtask

    task automatic test_saturation();
        int want_acc[3] = '{8, 15, 15};
        logic want_sat[3] = '{1'b0, 1'b1, 1'b1};
        clear_queues();
        idle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_ones(1'b0);
            checks++;
            if (int'(accs) != want_acc[i] || sats !== want_sat[i]) begin
                errors++; $display("FAIL sat_beat[%0d]: got acc=%0d sat=%b want %0d %b", i,
                                   accs, sats, want_acc[i], want_sat[i]);
            end
        end
        send_ones(1'b1);
        checks++;
        if (accs !== 4'd0 || sats !== 1'b0 || out8_q.size() != 4) begin
            errors++; $display("FAIL sat_clr: got acc=%0d sat=%b beats=%0d want 0 0 4",
                               accs, sats, out8_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        idle(1'b1, 1'b1);
        send_ones(1'b0);
        checks++;
        if (acc8 !== 16'd8) begin
            errors++; $display("FAIL rm_pre_acc: got %0d want 8", acc8);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'h00);
        checks++;
        if (pre_in_ready !== 1'b0) begin
            errors++; $display("FAIL rm_in_ready: got %b want 0", pre_in_ready);
        end
        checks++;
        if (out_valid8 !== 1'b0 || f8 !== 8'h00 || acc8 !== 16'd0 || accs !== 4'd0 ||
            sats !== 1'b0) begin
            errors++; $display("FAIL rm_state: got v=%b f=%h acc=%0d accs=%0d sat=%b want 0",
                               out_valid8, f8, acc8, accs, sats);
        end
        clear_queues();
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
        checks++;
        if (out8_q.size() != 0 || acc8 !== 16'd0) begin
            errors++; $display("FAIL rm_ghost: got %0d beats acc=%0d want 0 0", out8_q.size(),
                               acc8);
        end
    endtask

    task automatic test_random();
        int n;
        int sum8, sum1, bad;
        logic prev_stall;
        logic [7:0] prev_f;
        logic [7:0] exp;
        clear_queues();
        idle(1'b1, 1'b1);
        n = 0;
        prev_stall = 1'b0;
        prev_f = 8'h00;
        while (in_q.size() < 1000 && n < 20000) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom));
            if (prev_stall) begin
                checks++;
                if (pre_out_valid !== 1'b1 || pre_f !== prev_f) begin
                    errors++; $display("FAIL rnd_stall_hold: got v=%b f=%h want v=1 f=%h",
                                       pre_out_valid, pre_f, prev_f);
                end
            end
            prev_stall = pre_out_valid && !out_ready;
            prev_f = pre_f;
            n++;
        end
        while (out8_q.size() < in_q.size() && n < 20000) begin
            idle(1'b1, 1'b0);
            n++;
        end
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
        checks++;
        if (in_q.size() != 1000 || out8_q.size() != 1000) begin
            errors++; $display("FAIL rnd_count: got %0d in %0d out want 1000 (cycles %0d)",
                               in_q.size(), out8_q.size(), n);
        end
        sum8 = 0; sum1 = 0; bad = 0;
        for (int k = 0; k < out8_q.size() && k < in_q.size(); k++) begin
            exp = model_f(in_q[k]);
            sum8 += $countones(exp);
            sum1 += int'(exp[0]);
            checks++;
            if (out8_q[k] !== exp || out1_q[k] !== exp[0] || outs_q[k] !== exp) begin
                errors++;
                $display("FAIL rnd_f[%0d]: got %h/%b/%h want %h", k, out8_q[k], out1_q[k],
                         outs_q[k], exp);
            end
        end
        checks++;
        if (int'(acc8) != clamp(sum8, 65535) || int'(acc1) != clamp(sum1, 65535)) begin
            errors++; $display("FAIL rnd_acc: got %0d/%0d want %0d/%0d", acc8, acc1, sum8,
                               sum1);
        end
        checks++;
        if (int'(accs) != clamp(sum8, 15) || sats !== (sum8 >= 15)) begin
            errors++; $display("FAIL rnd_acc_sat: got %0d sat=%b want %0d sat=%b", accs, sats,
                               clamp(sum8, 15), (sum8 >= 15));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
        mode = 2'd0; a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
        test_reset();
        test_truth_table();
        test_modes();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
